// File: rtl/multdiv_pkg.sv
// Shared encodings and default sizing for the multdiv unit.
package multdiv_pkg;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned ITER_W = 5;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_RUN  = 2'b01,
      DIV_FIX  = 2'b10,
      DIV_DONE = 2'b11
   } div_state_e;

endpackage

// File: rtl/div_addsub_stage.sv
// One non-restoring step: add the divisor when the partial remainder is negative,
// subtract it otherwise. Arithmetic wraps at WIDTH+1 bits.
module div_addsub_stage #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH:0]   a,
   input  logic [WIDTH-1:0] m,
   input  logic             a_neg,
   output logic [WIDTH:0]   sum
);

   always_comb begin
      sum = a_neg ? (a + {1'b0, m}) : (a - {1'b0, m});
   end

endmodule

// File: rtl/div_nonrestoring_core.sv
// Iterative non-restoring divider: one quotient bit per clock, then a fix-up cycle.
// Define DIV_SIGNED_EN for two's-complement operands; default build is unsigned only.
module div_nonrestoring_core #(
   parameter int unsigned WIDTH  = multdiv_pkg::WIDTH,
   parameter int unsigned ITER_W = multdiv_pkg::ITER_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic [WIDTH-1:0] data_remainder,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   import multdiv_pkg::*;

   div_state_e        state;
   logic [ITER_W-1:0] iter;
   logic [WIDTH:0]    a_reg;
   logic [WIDTH-1:0]  q_reg;
   logic [WIDTH-1:0]  m_reg;

   logic [WIDTH:0]    stage_in;
   logic [WIDTH:0]    stage_out;
   logic [WIDTH-1:0]  rem_fix;
   logic [WIDTH-1:0]  op_a_mag;
   logic [WIDTH-1:0]  op_b_mag;
   logic [WIDTH-1:0]  quot_out;
   logic [WIDTH-1:0]  rem_out;

   // RUN feeds the shifted {A,Q}; FIX reuses the stage for the final A += M correction.
   always_comb begin
      stage_in = (state == DIV_FIX) ? a_reg : {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
      rem_fix  = a_reg[WIDTH] ? stage_out[WIDTH-1:0] : a_reg[WIDTH-1:0];
   end

   div_addsub_stage #(
      .WIDTH (WIDTH)
   ) u_addsub (
      .a     (stage_in),
      .m     (m_reg),
      .a_neg (a_reg[WIDTH]),
      .sum   (stage_out)
   );

`ifdef DIV_SIGNED_EN
   logic sign_q;
   logic sign_r;

   always_comb begin
      op_a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
      op_b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
      quot_out = sign_q ? -q_reg : q_reg;
      rem_out  = sign_r ? -rem_fix : rem_fix;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sign_q <= 1'b0;
         sign_r <= 1'b0;
      end else if (ctrl_DIV) begin
         sign_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         sign_r <= data_operandA[WIDTH-1];
      end
   end
`else
   always_comb begin
      op_a_mag = data_operandA;
      op_b_mag = data_operandB;
      quot_out = q_reg;
      rem_out  = rem_fix;
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= DIV_IDLE;
         iter           <= '0;
         a_reg          <= '0;
         q_reg          <= '0;
         m_reg          <= '0;
         data_result    <= '0;
         data_remainder <= '0;
         data_exception <= 1'b0;
      end else if (ctrl_DIV) begin
         // A start aborts whatever is in flight.
         m_reg <= op_b_mag;
         q_reg <= op_a_mag;
         a_reg <= '0;
         iter  <= '0;
         if (data_operandB == '0) begin
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b1;
            state          <= DIV_DONE;
         end else begin
            state <= DIV_RUN;
         end
      end else begin
         case (state)
            DIV_RUN: begin
               a_reg <= stage_out;
               q_reg <= {q_reg[WIDTH-2:0], ~stage_out[WIDTH]};
               iter  <= iter + 1'b1;
               if (iter == ITER_W'(WIDTH - 1)) state <= DIV_FIX;
            end
            DIV_FIX: begin
               a_reg          <= a_reg[WIDTH] ? stage_out : a_reg;
               data_result    <= quot_out;
               data_remainder <= rem_out;
               data_exception <= 1'b0;
               state          <= DIV_DONE;
            end
            DIV_DONE: state <= DIV_IDLE;
            default:  state <= DIV_IDLE;
         endcase
      end
   end

   assign data_resultRDY = (state == DIV_DONE);
   assign busy           = (state == DIV_RUN) || (state == DIV_FIX);

endmodule

// File: tb/tb_div_nonrestoring_core.sv
// Randomised self-checking bench for div_nonrestoring_core against an arithmetic reference.
module tb_div_nonrestoring_core;

   localparam int W = 32;

   logic         clk;
   logic         reset_n;
   logic         ctrl_DIV;
   logic [W-1:0] opA;
   logic [W-1:0] opB;
   logic [W-1:0] result;
   logic [W-1:0] remainder;
   logic         exc;
   logic         rdy;
   logic         busy;

   int tests = 0;
   int fails = 0;

   div_nonrestoring_core #(
      .WIDTH  (W),
      .ITER_W (5)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (opA),
      .data_operandB  (opB),
      .data_result    (result),
      .data_remainder (remainder),
      .data_exception (exc),
      .data_resultRDY (rdy),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r,
                                 output logic e);
      if (b == '0) begin
         q = '0;
         r = '0;
         e = 1'b1;
      end else begin
         e = 1'b0;
`ifdef DIV_SIGNED_EN
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = '0;
         end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
         end
`else
         q = a / b;
         r = a % b;
`endif
      end
   endfunction

   // Caller sits at a negedge; returns at the negedge following the start edge.
   task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
      ctrl_DIV = 1'b1;
      opA      = a;
      opB      = b;
      @(negedge clk);
      ctrl_DIV = 1'b0;
      opA      = $urandom;
      opB      = $urandom;
   endtask

   // Counts clock edges after the start edge until ready is seen (bounded).
   task automatic wait_rdy(output int n);
      n = 0;
      while (rdy !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] eq;
      logic [W-1:0] er;
      logic         ee;
      int           n;
      int           lat;
      model(a, b, eq, er, ee);
      lat = (b == '0) ? 0 : W + 1;
      start(a, b);
      wait_rdy(n);
      tests++;
      if (n !== lat) begin
         fails++;
         $display("FAIL %s latency: got %0d want %0d (a=%h b=%h)", name, n, lat, a, b);
      end
      tests++;
      if (result !== eq) begin
         fails++;
         $display("FAIL %s result: got %h want %h (a=%h b=%h)", name, result, eq, a, b);
      end
      tests++;
      if (remainder !== er) begin
         fails++;
         $display("FAIL %s remainder: got %h want %h (a=%h b=%h)", name, remainder, er, a, b);
      end
      tests++;
      if (exc !== ee) begin
         fails++;
         $display("FAIL %s exception: got %b want %b (a=%h b=%h)", name, exc, ee, a, b);
      end
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      ctrl_DIV = 1'b0;
      opA      = '0;
      opB      = '0;
      repeat (3) @(negedge clk);
      tests++;
      if ({result, remainder, exc, rdy, busy} !== '0) begin
         fails++;
         $display("FAIL reset outputs: got %h/%h/%b/%b/%b want all zero",
                  result, remainder, exc, rdy, busy);
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      check_op("basic_100_7", 32'd100, 32'd7);
      @(negedge clk);
      tests++;
      if (rdy !== 1'b0) begin
         fails++;
         $display("FAIL basic rdy_width: got %b want 0", rdy);
      end
   endtask

   task automatic test_div_zero();
      start(32'd5, 32'd0);
      tests++;
      if (busy !== 1'b0 || rdy !== 1'b1) begin
         fails++;
         $display("FAIL div0 busy/rdy: got %b/%b want 0/1", busy, rdy);
      end
      tests++;
      if (exc !== 1'b1 || result !== '0 || remainder !== '0) begin
         fails++;
         $display("FAIL div0 outputs: got exc=%b res=%h rem=%h want 1/0/0", exc, result, remainder);
      end
      @(negedge clk);
      tests++;
      if (rdy !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL div0 after: got rdy=%b busy=%b want 0/0", rdy, busy);
      end
   endtask

   task automatic test_restart();
      logic seen = 1'b0;
      start(32'd1000, 32'd3);
      repeat (9) begin
         if (rdy === 1'b1) seen = 1'b1;
         @(negedge clk);
      end
      check_op("restart_9_4", 32'd9, 32'd4);
      tests++;
      if (seen !== 1'b0) begin
         fails++;
         $display("FAIL restart aborted_rdy: got %b want 0", seen);
      end
   endtask

   task automatic test_reset_mid();
      logic seen = 1'b0;
      check_op("pre_reset", 32'd123456, 32'd789);
      start(32'hDEAD_BEEF, 32'd77);
      repeat (14) @(negedge clk);
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL reset_mid busy_before: got %b want 1", busy);
      end
      #2 reset_n = 1'b0;
      #1;
      tests++;
      if ({result, remainder, exc, rdy, busy} !== '0) begin
         fails++;
         $display("FAIL reset_mid outputs: got %h/%h/%b/%b/%b want all zero",
                  result, remainder, exc, rdy, busy);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (rdy === 1'b1) seen = 1'b1;
      end
      tests++;
      if (seen !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid spurious_rdy: got %b want 0", seen);
      end
      check_op("post_reset", 32'd1000, 32'd3);
   endtask

   task automatic test_max();
      check_op("max_div_1", 32'hFFFF_FFFF, 32'd1);
      @(negedge clk);
      tests++;
      if (rdy !== 1'b0) begin
         fails++;
         $display("FAIL max rdy_width: got %b want 0", rdy);
      end
   endtask

`ifdef DIV_SIGNED_EN
   task automatic test_signed();
      check_op("signed_m7_2", -32'sd7, 32'sd2);
      check_op("signed_min_m1", 32'h8000_0000, 32'hFFFF_FFFF);
      check_op("signed_7_m2", 32'sd7, -32'sd2);
   endtask
`endif

   // Ready cycles are followed immediately by the next start to cover DONE -> restart.
   task automatic test_back_to_back();
      logic [W-1:0] a;
      logic [W-1:0] b;
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         case ($urandom_range(0, 7))
            0:       b = '0;
            1:       b = W'($urandom_range(1, 15));
            2:       b = a + W'($urandom_range(1, 100));
            default: b = $urandom;
         endcase
         check_op("random", a, b);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_div_zero();
      test_restart();
      test_reset_mid();
      test_max();
`ifdef DIV_SIGNED_EN
      test_signed();
`endif
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
